// File: rtl/pin_formatter_array_pkg.sv
// pin_formatter_array_pkg: drive-format encodings and idle-level helper for the pin formatter
package pin_formatter_array_pkg;
    typedef enum logic [1:0] {
        FMT_NRZ = 2'd0,
        FMT_RZ  = 2'd1,
        FMT_R1  = 2'd2,
        FMT_SBC = 2'd3
    } fmt_e;
    // one bit per format, indexed by encoding; only R1 parks high
    localparam logic [3:0] IDLE_LEVEL = 4'b0100;
    function automatic logic idle_q(input fmt_e f, input logic q);
        return (f == FMT_NRZ) ? q : IDLE_LEVEL[f];
    endfunction
endpackage

// File: rtl/pin_formatter_array_chan.sv
// pin_format_chan: per-pin window compare, drive-format mux and registered pin output
module pin_format_chan
    import pin_formatter_array_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] le,
    input  logic [CNT_W-1:0] te,
    input  fmt_e             fmt,
    input  logic             d,
    output logic             q
);
    logic w;
    logic q_n;
    always_comb begin
        w   = run && (le <= cnt) && (cnt < te);
        q_n = !run ? idle_q(fmt, q) :
              w ? d :
              (fmt == FMT_NRZ) ? q :
              (fmt == FMT_SBC) ? ~d :
              (fmt == FMT_R1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= q_n;
    end
endmodule

// File: rtl/pin_formatter_array.sv
// pin_formatter_array: shared tester-cycle counter, vector slots and shadow timing feeding CHANNELS formatters
module pin_formatter_array
    import pin_formatter_array_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [CNT_W-1:0]          CYCLE_LENGTH,
    input  logic [CHANNELS*CNT_W-1:0] LEADING_EDGE,
    input  logic [CHANNELS*CNT_W-1:0] TRAILING_EDGE,
    input  logic [2*CHANNELS-1:0]     FF,
    input  logic [CHANNELS-1:0]       VEC_DATA,
    input  logic                      VEC_VALID,
    output logic                      VEC_READY,
    output logic [CHANNELS-1:0]       Q,
    output logic                      CYCLE_START,
    output logic                      UNDERRUN,
    output logic                      CFG_ERR
);
    logic [CNT_W-1:0]          cnt;
    logic                      run;
    logic                      next_full;
    logic [CHANNELS-1:0]       next_data;
    logic [CHANNELS-1:0]       cur;
    logic [CNT_W-1:0]          cl_sh;
    logic [CHANNELS*CNT_W-1:0] le_sh;
    logic [CHANNELS*CNT_W-1:0] te_sh;
    logic [2*CHANNELS-1:0]     ff_sh;
    logic                      boundary;
    logic                      accept;
    logic                      cfg_bad;
    always_comb begin
        boundary = run ? (cnt == cl_sh - 1'b1) : EN;
        accept   = VEC_VALID && !next_full;
        cfg_bad  = CYCLE_LENGTH < CNT_W'(2);
    end
    assign VEC_READY = !next_full;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            run         <= 1'b0;
            next_full   <= 1'b0;
            next_data   <= '0;
            cur         <= '0;
            cl_sh       <= '0;
            le_sh       <= '0;
            te_sh       <= '0;
            ff_sh       <= '0;
            CYCLE_START <= 1'b0;
            UNDERRUN    <= 1'b0;
            CFG_ERR     <= 1'b0;
        end else begin
            if (accept) next_data <= VEC_DATA;
            next_full   <= accept || (next_full && !boundary);
            CYCLE_START <= run && (cnt == '0);
            if (boundary) begin
                cl_sh <= CYCLE_LENGTH;
                le_sh <= LEADING_EDGE;
                te_sh <= TRAILING_EDGE;
                ff_sh <= FF;
                cnt   <= '0;
                run   <= EN && !cfg_bad;
                if (next_full) cur <= next_data;
                else           UNDERRUN <= 1'b1;
                if (EN && cfg_bad) CFG_ERR <= 1'b1;
            end else if (run) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pin_format_chan #(.CNT_W(CNT_W)) u_chan (
            .clk (CLK),
            .rst (RST),
            .run (run),
            .cnt (cnt),
            .le  (le_sh[i*CNT_W +: CNT_W]),
            .te  (te_sh[i*CNT_W +: CNT_W]),
            .fmt (fmt_e'(ff_sh[2*i +: 2])),
            .d   (cur[i]),
            .q   (Q[i])
        );
    end
endmodule

// File: tb/tb_pin_formatter_array.sv
// tb_pin_formatter_array: scenario tasks with a per-clock expected-pin scoreboard for channel 0
module tb_pin_formatter_array;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [7:0]  CYCLE_LENGTH = '0;
    logic [63:0] LEADING_EDGE = '0;
    logic [63:0] TRAILING_EDGE = '0;
    logic [15:0] FF = '0;
    logic [7:0]  VEC_DATA = '0;
    logic        VEC_VALID = 1'b0;
    logic        VEC_READY;
    logic [7:0]  Q;
    logic        CYCLE_START;
    logic        UNDERRUN;
    logic        CFG_ERR;

    typedef struct {
        logic [7:0] q;
        logic       cs;
    } exp_t;
    exp_t sb[$];
    logic wv[4];
    int   total = 0;
    int   passed = 0;

    pin_formatter_array #(.CHANNELS(8), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CYCLE_LENGTH(CYCLE_LENGTH),
        .LEADING_EDGE(LEADING_EDGE), .TRAILING_EDGE(TRAILING_EDGE), .FF(FF),
        .VEC_DATA(VEC_DATA), .VEC_VALID(VEC_VALID), .VEC_READY(VEC_READY),
        .Q(Q), .CYCLE_START(CYCLE_START), .UNDERRUN(UNDERRUN), .CFG_ERR(CFG_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; VEC_VALID = 1'b0; VEC_DATA = '0;
        CYCLE_LENGTH = '0; LEADING_EDGE = '0; TRAILING_EDGE = '0; FF = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        total++; if (Q !== 8'h00) $display("FAIL reset_q got %h exp 00", Q); else passed++;
        total++; if (VEC_READY !== 1'b1) $display("FAIL reset_ready got %b exp 1", VEC_READY); else passed++;
        total++; if (CYCLE_START !== 1'b0) $display("FAIL reset_cs got %b exp 0", CYCLE_START); else passed++;
        total++; if (UNDERRUN !== 1'b0) $display("FAIL reset_underrun got %b exp 0", UNDERRUN); else passed++;
        total++; if (CFG_ERR !== 1'b0) $display("FAIL reset_cfg_err got %b exp 0", CFG_ERR); else passed++;
        do_reset();
    endtask

    // CL=15, channel 0 window 5..9; other channels have an empty window and NRZ (stay 0)
    task automatic run_scenario(input string nm, input logic [1:0] fmt, input int nwords,
                                input int ncycles, input int le_chg_t);
        int   idx, le_port, le_cur, j, c;
        logic prev, w, v, e, acc, ue;
        exp_t x;
        do_reset();
        CYCLE_LENGTH = 8'd15;
        LEADING_EDGE[7:0] = 8'd5;
        TRAILING_EDGE[7:0] = 8'd10;
        FF[1:0] = fmt;
        le_port = 5; le_cur = 5; prev = 1'b0; idx = 0;
        VEC_VALID = 1'b1; VEC_DATA = {7'b0, wv[0]};
        @(posedge CLK); #1;
        idx = 1;
        EN = 1'b1; VEC_VALID = 1'b0;
        @(posedge CLK); #1;
        for (int t = 0; t < ncycles * 15; t++) begin
            j = t / 15; c = t % 15;
            if (c == 0) begin
                le_cur = le_port;
                ue = (j >= nwords);
                total++;
                if (UNDERRUN !== ue) $display("FAIL %s underrun cycle %0d got %b exp %b", nm, j, UNDERRUN, ue);
                else passed++;
            end
            v = wv[(j < nwords) ? j : nwords - 1];
            w = (le_cur <= c) && (c < 10);
            e = w ? v : (fmt == 2'd0) ? prev : (fmt == 2'd2) ? 1'b1 : (fmt == 2'd3) ? ~v : 1'b0;
            prev = e;
            sb.push_back('{q: {7'b0, e}, cs: (c == 0)});
            if (t == le_chg_t) begin
                LEADING_EDGE[7:0] = 8'd2;
                le_port = 2;
            end
            if (j == ncycles - 1) EN = 1'b0;
            VEC_VALID = (idx < nwords);
            VEC_DATA = {7'b0, wv[(idx < nwords) ? idx : 0]};
            acc = VEC_VALID && VEC_READY;
            @(posedge CLK); #1;
            if (acc) idx++;
            x = sb.pop_front();
            total++;
            if (Q !== x.q) $display("FAIL %s q cycle %0d cnt %0d got %h exp %h", nm, j, c, Q, x.q);
            else passed++;
            total++;
            if (CYCLE_START !== x.cs) $display("FAIL %s cycle_start cycle %0d cnt %0d got %b exp %b", nm, j, c, CYCLE_START, x.cs);
            else passed++;
        end
        VEC_VALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = (fmt == 2'd0) ? prev : (fmt == 2'd2);
            sb.push_back('{q: {7'b0, e}, cs: 1'b0});
            @(posedge CLK); #1;
            x = sb.pop_front();
            total++;
            if (Q !== x.q || CYCLE_START !== x.cs)
                $display("FAIL %s idle%0d got q=%h cs=%b exp q=%h cs=%b", nm, k, Q, CYCLE_START, x.q, x.cs);
            else passed++;
        end
    endtask

    task automatic test_rz();
        wv[0] = 1; wv[1] = 0; wv[2] = 1;
        run_scenario("rz", 2'd1, 3, 3, -1);
    endtask

    task automatic test_sbc();
        wv[0] = 1; wv[1] = 0;
        run_scenario("sbc", 2'd3, 2, 2, -1);
    endtask

    task automatic test_nrz();
        wv[0] = 1; wv[1] = 0; wv[2] = 1;
        run_scenario("nrz", 2'd0, 3, 3, -1);
    endtask

    task automatic test_underrun();
        wv[0] = 0; wv[1] = 1;
        run_scenario("underrun", 2'd1, 2, 4, -1);
    endtask

    task automatic test_le_change();
        wv[0] = 1; wv[1] = 1;
        run_scenario("le_change", 2'd1, 2, 2, 7);
    endtask

    task automatic test_cfg_err();
        do_reset();
        CYCLE_LENGTH = 8'd1;
        FF = 16'h0000;
        FF[1:0] = 2'd2;
        FF[3:2] = 2'd3;
        FF[5:4] = 2'd1;
        EN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (CFG_ERR !== 1'b1) $display("FAIL cfg_err flag got %b exp 1", CFG_ERR); else passed++;
        total++; if (Q !== 8'h01) $display("FAIL cfg_err idle_q got %h exp 01", Q); else passed++;
        total++; if (CYCLE_START !== 1'b0) $display("FAIL cfg_err cs got %b exp 0", CYCLE_START); else passed++;
        EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (CFG_ERR !== 1'b1) $display("FAIL cfg_err sticky got %b exp 1", CFG_ERR); else passed++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        CYCLE_LENGTH = 8'd15;
        LEADING_EDGE[7:0] = 8'd5;
        TRAILING_EDGE[7:0] = 8'd10;
        FF[1:0] = 2'd2;
        VEC_VALID = 1'b1; VEC_DATA = 8'h00;
        @(posedge CLK); #1;
        EN = 1'b1; VEC_DATA = 8'h01;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        total++; if (Q !== 8'h01) $display("FAIL rst_mid pre_q got %h exp 01", Q); else passed++;
        total++; if (VEC_READY !== 1'b0) $display("FAIL rst_mid pre_ready got %b exp 0", VEC_READY); else passed++;
        total++; if (CYCLE_START !== 1'b1) $display("FAIL rst_mid pre_cs got %b exp 1", CYCLE_START); else passed++;
        #2 RST = 1'b1;
        #1;
        total++; if (Q !== 8'h00) $display("FAIL rst_mid q got %h exp 00", Q); else passed++;
        total++; if (VEC_READY !== 1'b1) $display("FAIL rst_mid ready got %b exp 1", VEC_READY); else passed++;
        total++; if (CYCLE_START !== 1'b0) $display("FAIL rst_mid cs got %b exp 0", CYCLE_START); else passed++;
        total++; if (UNDERRUN !== 1'b0 || CFG_ERR !== 1'b0) $display("FAIL rst_mid flags got %b%b exp 00", UNDERRUN, CFG_ERR); else passed++;
        EN = 1'b0; VEC_VALID = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (Q !== 8'h00 || CYCLE_START !== 1'b0) $display("FAIL rst_mid post got q=%h cs=%b exp q=00 cs=0", Q, CYCLE_START); else passed++;
    endtask

    initial begin
        test_reset();
        test_rz();
        test_sbc();
        test_nrz();
        test_underrun();
        test_le_change();
        test_cfg_err();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
